// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM pipeline stage: branch encodings, the registered
// beat layout, and the branch-resolution helper.
package ex_mem_stage_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLT  = 3'b011,
      BR_BGE  = 3'b100,
      BR_JAL  = 3'b101
   } branch_type_e;

   typedef struct packed {
      logic [XLEN-1:0]   alu_out;
      logic [XLEN-1:0]   store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              br_taken;
      logic [XLEN-1:0]   pc_target;
   } ex_mem_beat_t;

   // BLT/BGE trust Negativo as-is; the ALU does not flag signed overflow.
   function automatic logic branch_decide(input logic [2:0] br_type,
                                          input logic       zero,
                                          input logic       negativo);
      logic taken_s;
      case (br_type)
         BR_BEQ:  taken_s = zero;
         BR_BNE:  taken_s = ~zero;
         BR_BLT:  taken_s = negativo;
         BR_BGE:  taken_s = ~negativo;
         BR_JAL:  taken_s = 1'b1;
         default: taken_s = 1'b0;
      endcase
      return taken_s;
   endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM -> MEM handshake bundle; slave is the stage view, master the driver view.
interface ex_mem_stage_if;
   import ex_mem_stage_pkg::*;

   logic              Flush;
   logic              In_Valid;
   logic              In_Ready;
   logic [XLEN-1:0]   ALU_Out;
   logic              Zero;
   logic              Negativo;
   logic [XLEN-1:0]   StoreData;
   logic [REG_AW-1:0] Rd;
   logic              RegWrite;
   logic              MemRead;
   logic              MemWrite;
   logic [2:0]        BranchType;
   logic [XLEN-1:0]   PC_Branch;
   logic              Out_Valid;
   logic              Out_Ready;
   logic [XLEN-1:0]   Out_ALU_Out;
   logic [XLEN-1:0]   Out_StoreData;
   logic [REG_AW-1:0] Out_Rd;
   logic              Out_RegWrite;
   logic              Out_MemRead;
   logic              Out_MemWrite;
   logic              Branch_Taken;
   logic [XLEN-1:0]   PC_Target;
   logic [CNT_W-1:0]  Beat_Count;

   modport slave (
      input  Flush, In_Valid, ALU_Out, Zero, Negativo, StoreData, Rd, RegWrite,
             MemRead, MemWrite, BranchType, PC_Branch, Out_Ready,
      output In_Ready, Out_Valid, Out_ALU_Out, Out_StoreData, Out_Rd, Out_RegWrite,
             Out_MemRead, Out_MemWrite, Branch_Taken, PC_Target, Beat_Count
   );

   modport master (
      output Flush, In_Valid, ALU_Out, Zero, Negativo, StoreData, Rd, RegWrite,
             MemRead, MemWrite, BranchType, PC_Branch, Out_Ready,
      input  In_Ready, Out_Valid, Out_ALU_Out, Out_StoreData, Out_Rd, Out_RegWrite,
             Out_MemRead, Out_MemWrite, Branch_Taken, PC_Target, Beat_Count
   );

endinterface

// File: rtl/ex_mem_stage_skid_buffer.sv
// Two-entry skid buffer: main register drives the output, skid register absorbs
// the beat that arrives while the consumer stalls, so in_ready is a flop.
module skid_buffer #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   T     main_r;
   T     skid_r;
   T     main_n_s;
   T     skid_n_s;
   logic main_vld_r;
   logic skid_vld_r;
   logic main_vld_n_s;
   logic skid_vld_n_s;
   logic in_ready_r;
   logic accept_s;
   logic deliver_s;

   assign accept_s  = in_valid & in_ready_r & ~flush;
   assign deliver_s = main_vld_r & out_ready;

   // Next-state of both entries; skid always drains into main before new data.
   always_comb begin
      main_n_s     = main_r;
      skid_n_s     = skid_r;
      main_vld_n_s = main_vld_r;
      skid_vld_n_s = skid_vld_r;
      if (flush) begin
         main_vld_n_s = 1'b0;
         skid_vld_n_s = 1'b0;
      end else if (deliver_s) begin
         if (skid_vld_r) begin
            main_n_s     = skid_r;
            main_vld_n_s = 1'b1;
            skid_vld_n_s = accept_s;
            if (accept_s) begin
               skid_n_s = in_data;
            end else begin
               skid_n_s = skid_r;
            end
         end else begin
            main_vld_n_s = accept_s;
            if (accept_s) begin
               main_n_s = in_data;
            end else begin
               main_n_s = main_r;
            end
         end
      end else if (accept_s) begin
         if (main_vld_r) begin
            skid_n_s     = in_data;
            skid_vld_n_s = 1'b1;
         end else begin
            main_n_s     = in_data;
            main_vld_n_s = 1'b1;
         end
      end else begin
         main_vld_n_s = main_vld_r;
      end
   end

   // Entry registers and the registered ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_r     <= '0;
         skid_r     <= '0;
         main_vld_r <= 1'b0;
         skid_vld_r <= 1'b0;
         in_ready_r <= 1'b0;
      end else begin
         main_r     <= main_n_s;
         skid_r     <= skid_n_s;
         main_vld_r <= main_vld_n_s;
         skid_vld_r <= skid_vld_n_s;
         in_ready_r <= ~(main_vld_n_s & skid_vld_n_s);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = main_vld_r;
   assign out_data  = main_r;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: resolves the branch at capture, buffers beats in a 2-entry skid
// buffer toward MEM, and counts accepted beats.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ex_mem_stage_if.slave  bus
);

   ex_mem_beat_t     in_beat_s;
   ex_mem_beat_t     out_beat_s;
   logic             in_ready_s;
   logic             accept_s;
   logic [CNT_W-1:0] beat_count_r;

   // Pack the offered beat with its branch decision already resolved.
   always_comb begin
      in_beat_s            = '0;
      in_beat_s.alu_out    = bus.ALU_Out;
      in_beat_s.store_data = bus.StoreData;
      in_beat_s.rd         = bus.Rd;
      in_beat_s.reg_write  = bus.RegWrite;
      in_beat_s.mem_read   = bus.MemRead;
      in_beat_s.mem_write  = bus.MemWrite;
      in_beat_s.br_taken   = branch_decide(bus.BranchType, bus.Zero, bus.Negativo);
      if (in_beat_s.br_taken) begin
         in_beat_s.pc_target = bus.PC_Branch;
      end else begin
         in_beat_s.pc_target = '0;
      end
   end

   skid_buffer #(.T(ex_mem_beat_t)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.Flush),
      .in_valid  (bus.In_Valid),
      .in_ready  (in_ready_s),
      .in_data   (in_beat_s),
      .out_valid (bus.Out_Valid),
      .out_ready (bus.Out_Ready),
      .out_data  (out_beat_s)
   );

   // A beat dropped by Flush never counts as accepted.
   assign accept_s = bus.In_Valid & in_ready_s & ~bus.Flush;

   // Accepted-beat counter, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_count_r <= '0;
      end else if (accept_s) begin
         beat_count_r <= beat_count_r + CNT_W'(1);
      end else begin
         beat_count_r <= beat_count_r;
      end
   end

   assign bus.In_Ready      = in_ready_s;
   assign bus.Out_ALU_Out   = out_beat_s.alu_out;
   assign bus.Out_StoreData = out_beat_s.store_data;
   assign bus.Out_Rd        = out_beat_s.rd;
   assign bus.Out_RegWrite  = out_beat_s.reg_write;
   assign bus.Out_MemRead   = out_beat_s.mem_read;
   assign bus.Out_MemWrite  = out_beat_s.mem_write;
   assign bus.Branch_Taken  = out_beat_s.br_taken;
   assign bus.PC_Target     = out_beat_s.pc_target;
   assign bus.Beat_Count    = beat_count_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a queue-based reference model.
module tb_ex_mem_stage;
   import ex_mem_stage_pkg::*;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        tk;
      logic [31:0] tgt;
   } exp_beat_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_mem_stage_if bus();
   ex_mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

   exp_beat_t   q[$];
   bit          m_ready;
   logic [31:0] m_count;
   bit          last_acc;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit exp_taken(input int bt, input bit z, input bit n);
      if (bt == 1) return z;
      if (bt == 2) return !z;
      if (bt == 3) return n;
      if (bt == 4) return !n;
      if (bt == 5) return 1'b1;
      return 1'b0;
   endfunction

   task automatic set_beat(input logic [31:0] alu, input logic [2:0] bt,
                           input logic z, input logic n, input logic [31:0] pc);
      bus.ALU_Out    = alu;
      bus.BranchType = bt;
      bus.Zero       = z;
      bus.Negativo   = n;
      bus.PC_Branch  = pc;
      bus.StoreData  = $urandom;
      bus.Rd         = 5'($urandom);
      bus.RegWrite   = 1'($urandom);
      bus.MemRead    = 1'($urandom);
      bus.MemWrite   = 1'($urandom);
   endtask

   // Check outputs at the falling edge, then advance the model over the rising edge.
   task automatic cycle();
      exp_beat_t b;
      @(negedge clk);
      check_value("out_valid", bus.Out_Valid, (q.size() > 0));
      check_value("in_ready", bus.In_Ready, m_ready);
      check_value("beat_count", bus.Beat_Count, m_count);
      if (q.size() > 0) begin
         check_value("out_alu", bus.Out_ALU_Out, q[0].alu);
         check_value("out_store", bus.Out_StoreData, q[0].store);
         check_value("out_rd", bus.Out_Rd, q[0].rd);
         check_value("out_ctrl", {bus.Out_RegWrite, bus.Out_MemRead, bus.Out_MemWrite},
                     {q[0].rw, q[0].mr, q[0].mw});
         check_value("br_taken", bus.Branch_Taken, q[0].tk);
         check_value("pc_target", bus.PC_Target, q[0].tgt);
      end
      last_acc = 1'b0;
      if (reset) begin
         q.delete();
         m_ready = 1'b0;
         m_count = 32'd0;
      end else begin
         if (q.size() > 0 && bus.Out_Ready) void'(q.pop_front());
         if (bus.Flush) begin
            q.delete();
         end else if (bus.In_Valid && m_ready) begin
            b.alu   = bus.ALU_Out;
            b.store = bus.StoreData;
            b.rd    = bus.Rd;
            b.rw    = bus.RegWrite;
            b.mr    = bus.MemRead;
            b.mw    = bus.MemWrite;
            b.tk    = exp_taken(int'(bus.BranchType), bus.Zero, bus.Negativo);
            b.tgt   = b.tk ? bus.PC_Branch : 32'd0;
            q.push_back(b);
            m_count  = m_count + 32'd1;
            last_acc = 1'b1;
         end
         m_ready = (q.size() < 2);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          guard;
      logic [31:0] saved;
      logic [2:0]  bt_tab[4];
      logic        exp_tab[4];

      reset        = 1'b1;
      bus.Flush    = 1'b0;
      bus.In_Valid = 1'b0;
      bus.Out_Ready = 1'b0;
      set_beat(32'd0, 3'd0, 1'b0, 1'b0, 32'd0);
      m_ready = 1'b0;
      m_count = 32'd0;
      @(posedge clk);
      #1;

      // Reset held for three cycles.
      repeat (3) cycle();
      check_value("rst_out_alu", bus.Out_ALU_Out, 32'd0);
      check_value("rst_taken", bus.Branch_Taken, 1'b0);
      check_value("rst_target", bus.PC_Target, 32'd0);
      reset = 1'b0;
      cycle();
      check_value("ready_after_reset", bus.In_Ready, 1'b1);

      // BEQ taken, BNE not taken with same flags.
      bus.Out_Ready = 1'b1;
      bus.In_Valid  = 1'b1;
      set_beat(32'd0, 3'b001, 1'b1, 1'b0, 32'h100);
      cycle();
      check_value("beq_valid", bus.Out_Valid, 1'b1);
      check_value("beq_taken", bus.Branch_Taken, 1'b1);
      check_value("beq_target", bus.PC_Target, 32'h100);
      set_beat(32'd0, 3'b010, 1'b1, 1'b0, 32'h100);
      cycle();
      check_value("bne_taken", bus.Branch_Taken, 1'b0);
      check_value("bne_target", bus.PC_Target, 32'd0);

      // BLT/BGE with Negativo=1, reserved code, JAL.
      bt_tab  = '{3'b011, 3'b100, 3'b110, 3'b101};
      exp_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         set_beat(32'(i + 10), bt_tab[i], 1'b0, 1'b1, 32'h2000 + 32'(i));
         cycle();
         check_value("branch_tab", bus.Branch_Taken, exp_tab[i]);
      end
      bus.In_Valid = 1'b0;
      repeat (2) cycle();

      // Back-pressure: two beats fill the stage, the third waits upstream.
      bus.Out_Ready = 1'b0;
      bus.In_Valid  = 1'b1;
      set_beat(32'd1, 3'd0, 1'b0, 1'b0, 32'd0);
      cycle();
      set_beat(32'd2, 3'd0, 1'b0, 1'b0, 32'd0);
      cycle();
      check_value("full_ready", bus.In_Ready, 1'b0);
      check_value("full_head", bus.Out_ALU_Out, 32'd1);
      set_beat(32'd3, 3'd0, 1'b0, 1'b0, 32'd0);
      repeat (3) cycle();
      check_value("held_head", bus.Out_ALU_Out, 32'd1);
      check_value("held_count", bus.Beat_Count, m_count);
      bus.Out_Ready = 1'b1;
      guard = 0;
      do begin
         cycle();
         guard++;
      end while (!last_acc && guard < 10);
      bus.In_Valid = 1'b0;
      check_value("beat3_count", bus.Beat_Count, m_count);
      repeat (4) cycle();

      // Flush while FULL with a beat offered.
      bus.Out_Ready = 1'b0;
      bus.In_Valid  = 1'b1;
      set_beat(32'h11, 3'd0, 1'b0, 1'b0, 32'd0);
      cycle();
      set_beat(32'h22, 3'd0, 1'b0, 1'b0, 32'd0);
      cycle();
      saved = m_count;
      bus.Flush = 1'b1;
      set_beat(32'hDEAD, 3'd0, 1'b0, 1'b0, 32'd0);
      cycle();
      bus.Flush    = 1'b0;
      bus.In_Valid = 1'b0;
      check_value("flush_valid", bus.Out_Valid, 1'b0);
      check_value("flush_ready", bus.In_Ready, 1'b1);
      check_value("flush_count", bus.Beat_Count, saved);
      bus.Out_Ready = 1'b1;
      repeat (3) cycle();

      // Mid-operation reset, then 100 back-to-back beats.
      bus.In_Valid = 1'b1;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      bus.In_Valid = 1'b0;
      cycle();
      bus.In_Valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         set_beat($urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom);
         cycle();
         check_value("throughput", bus.Beat_Count, 32'(i + 1));
      end
      check_value("count_100", bus.Beat_Count, 32'd100);

      // Random traffic with 50% back-pressure and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         bus.In_Valid  = 1'($urandom);
         bus.Out_Ready = 1'($urandom);
         bus.Flush     = ($urandom_range(0, 31) == 0);
         set_beat($urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom);
         cycle();
      end
      bus.In_Valid  = 1'b0;
      bus.Flush     = 1'b0;
      bus.Out_Ready = 1'b1;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
